// File: rtl/tl_phase_scheduler_if.sv
// Signal bundle between the intersection controller and its surroundings:
// request/hold inputs from the synchronisers, lamp and status outputs to the drivers.
interface tl_phase_scheduler_if;
  logic       ped_ns_req;
  logic       ped_ew_req;
  logic       hold;
  logic [2:0] NS;
  logic [2:0] EW;
  logic [2:0] P_NS;
  logic [2:0] P_EW;
  logic [2:0] phase;
  logic       ped_ns_pend;
  logic       ped_ew_pend;
  logic       phase_done;

  modport master (
    output ped_ns_req, ped_ew_req, hold,
    input  NS, EW, P_NS, P_EW, phase, ped_ns_pend, ped_ew_pend, phase_done
  );

  modport slave (
    input  ped_ns_req, ped_ew_req, hold,
    output NS, EW, P_NS, P_EW, phase, ped_ns_pend, ped_ew_pend, phase_done
  );
endinterface

// File: rtl/tl_phase_scheduler.sv
// Two-road intersection phase scheduler with counted dwell per phase and a
// latched-request, all-vehicle-red pedestrian walk phase.
//
// state    | meaning
// ---------+--------------------------------------------------
// NS_GRN   | NS green, EW red
// NS_YEL   | NS yellow, EW red
// ALLRED_A | clearance after NS, walk or EW green next
// EW_GRN   | EW green, NS red
// EW_YEL   | EW yellow, NS red
// ALLRED_B | clearance after EW (reset state), walk or NS green next
// WALK     | all vehicles red, requested crossings green
// ILLEGAL  | unused encoding, recovers to ALLRED_B
module tl_phase_scheduler #(
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              res_n,
  tl_phase_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    NS_GRN   = 3'd0,
    NS_YEL   = 3'd1,
    ALLRED_A = 3'd2,
    EW_GRN   = 3'd3,
    EW_YEL   = 3'd4,
    ALLRED_B = 3'd5,
    WALK     = 3'd6,
    ILLEGAL  = 3'd7
  } state_t;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  // A dwell of 0 behaves like 1: the counter loads 0 and expires at once.
  localparam logic [CNT_W-1:0] D_GRN    = (GREEN_T  == 0) ? '0 : CNT_W'(GREEN_T  - 1);
  localparam logic [CNT_W-1:0] D_YEL    = (YELLOW_T == 0) ? '0 : CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] D_ALLRED = (ALLRED_T == 0) ? '0 : CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] D_WALK   = (WALK_T   == 0) ? '0 : CNT_W'(WALK_T   - 1);

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_ns_q, pend_ns_d, pend_ew_q, pend_ew_d;
  logic             walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  logic [2:0]       ns_q, ns_d, ew_q, ew_d, pns_q, pns_d, pew_q, pew_d;
  logic             any_pending;

  function automatic logic [CNT_W-1:0] dwell(state_t s);
    case (s)
      NS_GRN, EW_GRN: dwell = D_GRN;
      NS_YEL, EW_YEL: dwell = D_YEL;
      WALK:           dwell = D_WALK;
      default:        dwell = D_ALLRED;
    endcase
  endfunction

  assign any_pending = pend_ns_q | pend_ew_q | bus.ped_ns_req | bus.ped_ew_req;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q   <= ALLRED_B;
      ret_q     <= NS_GRN;
      cnt_q     <= D_ALLRED;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      ns_q      <= RED;
      ew_q      <= RED;
      pns_q     <= RED;
      pew_q     <= RED;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      cnt_q     <= cnt_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      ns_q      <= ns_d;
      ew_q      <= ew_d;
      pns_q     <= pns_d;
      pew_q     <= pew_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    walk_ns_d = walk_ns_q;
    walk_ew_d = walk_ew_q;
    pend_ns_d = pend_ns_q | bus.ped_ns_req;
    pend_ew_d = pend_ew_q | bus.ped_ew_req;

    if (state_q == ILLEGAL) begin
      state_d = ALLRED_B;
      cnt_d   = D_ALLRED;
    end else if (!bus.hold) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        case (state_q)
          NS_GRN: state_d = NS_YEL;
          NS_YEL: state_d = ALLRED_A;
          ALLRED_A: begin
            state_d = any_pending ? WALK : EW_GRN;
            if (any_pending) ret_d = EW_GRN;
          end
          EW_GRN: state_d = EW_YEL;
          EW_YEL: state_d = ALLRED_B;
          ALLRED_B: begin
            state_d = any_pending ? WALK : NS_GRN;
            if (any_pending) ret_d = NS_GRN;
          end
          WALK:    state_d = ret_q;
          default: state_d = ALLRED_B;
        endcase
        cnt_d = dwell(state_d);
        // Requests seen in the entry cycle are absorbed by this walk window.
        if (state_d == WALK) begin
          walk_ns_d = pend_ns_q | bus.ped_ns_req;
          walk_ew_d = pend_ew_q | bus.ped_ew_req;
          pend_ns_d = 1'b0;
          pend_ew_d = 1'b0;
        end
      end
    end
  end

  // Lamps are registered decodes of the next state so they switch with it.
  always_comb begin
    ns_d  = RED;
    ew_d  = RED;
    pns_d = RED;
    pew_d = RED;
    case (state_d)
      NS_GRN: ns_d = GRN;
      NS_YEL: ns_d = YEL;
      EW_GRN: ew_d = GRN;
      EW_YEL: ew_d = YEL;
      WALK: begin
        pns_d = walk_ns_d ? GRN : RED;
        pew_d = walk_ew_d ? GRN : RED;
      end
      default: ;
    endcase
  end

  assign bus.NS          = ns_q;
  assign bus.EW          = ew_q;
  assign bus.P_NS        = pns_q;
  assign bus.P_EW        = pew_q;
  assign bus.phase       = state_q;
  assign bus.ped_ns_pend = pend_ns_q;
  assign bus.ped_ew_pend = pend_ew_q;
  assign bus.phase_done  = (cnt_q == '0) & ~bus.hold;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// Directed bench for tl_phase_scheduler: default loop timing, walk insertion,
// hold behaviour and asynchronous reset, with hand-computed expectations.
module tb_tl_phase_scheduler;

  logic clk;
  logic res_n;
  int   n_checks;
  int   n_errors;

  tl_phase_scheduler_if bus ();

  tl_phase_scheduler dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in ALLRED_B with cnt==0 (its expiry cycle), 1 ns after an edge.
  task automatic do_reset();
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b0;
    bus.hold       = 1'b0;
    res_n          = 1'b0;
    cyc();
    cyc();
    res_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int exp_ph [23];
    logic [2:0] exp_ns, exp_ew;
    logic exp_done;
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b0;
    bus.hold       = 1'b0;
    res_n          = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++;
    if (bus.NS !== 3'b001 || bus.EW !== 3'b001 || bus.P_NS !== 3'b001 || bus.P_EW !== 3'b001) begin
      n_errors++;
      $display("FAIL reset_lights: got NS=%b EW=%b P_NS=%b P_EW=%b, want all 001", bus.NS, bus.EW, bus.P_NS, bus.P_EW);
    end
    n_checks++;
    if (bus.phase !== 3'd5 || bus.ped_ns_pend !== 1'b0 || bus.ped_ew_pend !== 1'b0 || bus.phase_done !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_state: got phase=%0d pend=%b%b done=%b, want phase=5 pend=00 done=1",
               bus.phase, bus.ped_ns_pend, bus.ped_ew_pend, bus.phase_done);
    end
    res_n = 1'b1;
    // Expected phase after k edges since release (index k-1).
    for (int k = 1; k <= 23; k++) begin
      if (k <= 8)       exp_ph[k-1] = 0;
      else if (k <= 10) exp_ph[k-1] = 1;
      else if (k == 11) exp_ph[k-1] = 2;
      else if (k <= 19) exp_ph[k-1] = 3;
      else if (k <= 21) exp_ph[k-1] = 4;
      else if (k == 22) exp_ph[k-1] = 5;
      else              exp_ph[k-1] = 0;
    end
    for (int k = 1; k <= 23; k++) begin
      cyc();
      exp_ns   = (exp_ph[k-1] == 0) ? 3'b100 : (exp_ph[k-1] == 1) ? 3'b010 : 3'b001;
      exp_ew   = (exp_ph[k-1] == 3) ? 3'b100 : (exp_ph[k-1] == 4) ? 3'b010 : 3'b001;
      exp_done = (k == 8 || k == 10 || k == 11 || k == 19 || k == 21 || k == 22);
      n_checks++;
      if (bus.phase !== 3'(exp_ph[k-1]) || bus.NS !== exp_ns || bus.EW !== exp_ew || bus.phase_done !== exp_done) begin
        n_errors++;
        $display("FAIL loop_cycle_%0d: got phase=%0d NS=%b EW=%b done=%b, want phase=%0d NS=%b EW=%b done=%b",
                 k, bus.phase, bus.NS, bus.EW, bus.phase_done, exp_ph[k-1], exp_ns, exp_ew, exp_done);
      end
    end
  endtask

  task automatic test_ped_ns();
    do_reset();
    cyc();
    bus.ped_ns_req = 1'b1;
    cyc();
    bus.ped_ns_req = 1'b0;
    n_checks++;
    if (bus.ped_ns_pend !== 1'b1 || bus.phase !== 3'd0) begin
      n_errors++;
      $display("FAIL ped_ns_latch: got pend=%b phase=%0d, want pend=1 phase=0", bus.ped_ns_pend, bus.phase);
    end
    repeat (9) cyc();
    n_checks++;
    if (bus.phase !== 3'd2 || bus.ped_ns_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL ped_ns_allred: got phase=%0d pend=%b, want phase=2 pend=1", bus.phase, bus.ped_ns_pend);
    end
    for (int w = 1; w <= 4; w++) begin
      cyc();
      n_checks++;
      if (bus.phase !== 3'd6 || bus.P_NS !== 3'b100 || bus.P_EW !== 3'b001 ||
          bus.NS !== 3'b001 || bus.EW !== 3'b001 || bus.ped_ns_pend !== 1'b0) begin
        n_errors++;
        $display("FAIL ped_ns_walk_%0d: got phase=%0d P_NS=%b P_EW=%b NS=%b EW=%b pend=%b, want 6 100 001 001 001 0",
                 w, bus.phase, bus.P_NS, bus.P_EW, bus.NS, bus.EW, bus.ped_ns_pend);
      end
    end
    cyc();
    n_checks++;
    if (bus.phase !== 3'd3 || bus.EW !== 3'b100 || bus.P_NS !== 3'b001 || bus.ped_ns_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL ped_ns_return: got phase=%0d EW=%b P_NS=%b pend=%b, want 3 100 001 0",
               bus.phase, bus.EW, bus.P_NS, bus.ped_ns_pend);
    end
  endtask

  task automatic test_both_in_expiry();
    do_reset();
    bus.ped_ns_req = 1'b1;
    bus.ped_ew_req = 1'b1;
    cyc();
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b0;
    n_checks++;
    if (bus.phase !== 3'd6 || bus.P_NS !== 3'b100 || bus.P_EW !== 3'b100 ||
        bus.ped_ns_pend !== 1'b0 || bus.ped_ew_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL both_walk_entry: got phase=%0d P_NS=%b P_EW=%b pend=%b%b, want 6 100 100 00",
               bus.phase, bus.P_NS, bus.P_EW, bus.ped_ns_pend, bus.ped_ew_pend);
    end
    repeat (3) cyc();
    n_checks++;
    if (bus.phase !== 3'd6 || bus.phase_done !== 1'b1) begin
      n_errors++;
      $display("FAIL both_walk_last: got phase=%0d done=%b, want 6 1", bus.phase, bus.phase_done);
    end
    cyc();
    n_checks++;
    if (bus.phase !== 3'd0 || bus.NS !== 3'b100 || bus.P_NS !== 3'b001 || bus.P_EW !== 3'b001 ||
        bus.ped_ns_pend !== 1'b0 || bus.ped_ew_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL both_return: got phase=%0d NS=%b P_NS=%b P_EW=%b pend=%b%b, want 0 100 001 001 00",
               bus.phase, bus.NS, bus.P_NS, bus.P_EW, bus.ped_ns_pend, bus.ped_ew_pend);
    end
  endtask

  task automatic test_req_during_walk();
    do_reset();
    bus.ped_ns_req = 1'b1;
    cyc();
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b1;
    cyc();
    bus.ped_ew_req = 1'b0;
    n_checks++;
    if (bus.phase !== 3'd6 || bus.P_NS !== 3'b100 || bus.P_EW !== 3'b001 || bus.ped_ew_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL walk_req_unchanged: got phase=%0d P_NS=%b P_EW=%b ew_pend=%b, want 6 100 001 1",
               bus.phase, bus.P_NS, bus.P_EW, bus.ped_ew_pend);
    end
    cyc(); cyc(); cyc();
    n_checks++;
    if (bus.phase !== 3'd0 || bus.ped_ew_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL walk_req_return: got phase=%0d ew_pend=%b, want 0 1", bus.phase, bus.ped_ew_pend);
    end
    repeat (11) cyc();
    n_checks++;
    if (bus.phase !== 3'd6 || bus.P_EW !== 3'b100 || bus.P_NS !== 3'b001 || bus.ped_ew_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL second_walk: got phase=%0d P_EW=%b P_NS=%b ew_pend=%b, want 6 100 001 0",
               bus.phase, bus.P_EW, bus.P_NS, bus.ped_ew_pend);
    end
  endtask

  task automatic test_hold();
    do_reset();
    cyc();
    repeat (7) cyc();
    n_checks++;
    if (bus.phase !== 3'd0 || bus.phase_done !== 1'b1) begin
      n_errors++;
      $display("FAIL hold_pre: got phase=%0d done=%b, want 0 1", bus.phase, bus.phase_done);
    end
    bus.hold = 1'b1;
    #1;
    n_checks++;
    if (bus.phase_done !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_done_mask: got done=%b, want 0", bus.phase_done);
    end
    for (int h = 1; h <= 5; h++) begin
      cyc();
      n_checks++;
      if (bus.phase !== 3'd0 || bus.NS !== 3'b100 || bus.phase_done !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle_%0d: got phase=%0d NS=%b done=%b, want 0 100 0",
                 h, bus.phase, bus.NS, bus.phase_done);
      end
    end
    bus.hold = 1'b0;
    #1;
    n_checks++;
    if (bus.phase_done !== 1'b1 || bus.NS !== 3'b100) begin
      n_errors++;
      $display("FAIL hold_release: got done=%b NS=%b, want 1 100", bus.phase_done, bus.NS);
    end
    cyc();
    n_checks++;
    if (bus.phase !== 3'd1 || bus.NS !== 3'b010) begin
      n_errors++;
      $display("FAIL hold_to_yellow: got phase=%0d NS=%b, want 1 010", bus.phase, bus.NS);
    end
  endtask

  task automatic test_reset_mid_walk();
    do_reset();
    bus.ped_ns_req = 1'b1;
    bus.ped_ew_req = 1'b1;
    cyc();
    bus.ped_ns_req = 1'b0;
    cyc();
    bus.ped_ew_req = 1'b0;
    n_checks++;
    if (bus.phase !== 3'd6 || bus.P_NS !== 3'b100 || bus.ped_ew_pend !== 1'b1) begin
      n_errors++;
      $display("FAIL midwalk_pre: got phase=%0d P_NS=%b ew_pend=%b, want 6 100 1",
               bus.phase, bus.P_NS, bus.ped_ew_pend);
    end
    #2;
    res_n = 1'b0;
    #1;
    n_checks++;
    if (bus.P_NS !== 3'b001 || bus.P_EW !== 3'b001 || bus.phase !== 3'd5 ||
        bus.ped_ns_pend !== 1'b0 || bus.ped_ew_pend !== 1'b0) begin
      n_errors++;
      $display("FAIL midwalk_async_reset: got P_NS=%b P_EW=%b phase=%0d pend=%b%b, want 001 001 5 00",
               bus.P_NS, bus.P_EW, bus.phase, bus.ped_ns_pend, bus.ped_ew_pend);
    end
    cyc();
    res_n = 1'b1;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    res_n          = 1'b0;
    bus.ped_ns_req = 1'b0;
    bus.ped_ew_req = 1'b0;
    bus.hold       = 1'b0;
    test_reset();
    test_ped_ns();
    test_both_in_expiry();
    test_req_during_walk();
    test_hold();
    test_reset_mid_walk();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
